// File: rtl/systolic_array_if.sv
// systolic_array_if
//   Bundles the activation stream, weight-load handshake, swap pulse,
//   runtime shape configuration and result stream of systolic_array.
//   master : the side that feeds vectors/weights and consumes results
//   slave  : the systolic array itself
//   Ports (slave view):
//     in_valid, in_data            activation vector in
//     w_valid, w_data / w_ready    weight row load / accept
//     sw_in                        shadow->active swap pulse
//     cfg_valid, cfg_rows/cols     active matrix shape
//     out_valid, out_data, busy    result vector out, pipeline occupancy
interface systolic_array_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic                         in_valid;
  logic [ROWS*DATA_W-1:0]       in_data;
  logic                         w_valid;
  logic                         w_ready;
  logic [COLS*DATA_W-1:0]       w_data;
  logic                         sw_in;
  logic                         cfg_valid;
  logic [$clog2(ROWS+1)-1:0]    cfg_rows;
  logic [$clog2(COLS+1)-1:0]    cfg_cols;
  logic                         out_valid;
  logic [COLS*ACC_W-1:0]        out_data;
  logic                         busy;

  modport master (
    output in_valid, in_data, w_valid, w_data, sw_in, cfg_valid, cfg_rows, cfg_cols,
    input  w_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, w_valid, w_data, sw_in, cfg_valid, cfg_rows, cfg_cols,
    output w_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/systolic_array.sv
// systolic_array
//   ROWS x COLS weight-stationary matrix-vector engine. Activations enter
//   row-skewed, partial sums flow down each column, and column results are
//   deskewed so one output vector lands on one beat:
//     out_data[c] = sum_r x[r] * W[r][c]   (modulo 2^ACC_W)
//   Each PE double-buffers its weight (shadow/active); a swap travels as a
//   diagonal wavefront so streaming never has to pause.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : systolic_array_if.slave (vector/weight/config in, result out)
module systolic_array #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  systolic_array_if.slave  bus
);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam int COL_W = $clog2(COLS + 1);

  logic [ROW_W-1:0] active_rows;
  logic [COL_W-1:0] active_cols;

  // Inter-PE wiring: activation/valid entering each PE, psum leaving it,
  // the shadow weight each PE exposes to the one below, and per-PE
  // valid/swap register taps used for busy and w_ready.
  logic signed [DATA_W-1:0] act_in [ROWS][COLS];
  logic                     v_in   [ROWS][COLS];
  logic signed [ACC_W-1:0]  psum   [ROWS][COLS];
  logic signed [DATA_W-1:0] shadow [ROWS][COLS];
  logic                     v_bit  [ROWS][COLS];
  logic                     sw_bit [ROWS][COLS];
  logic signed [ACC_W-1:0]  col_res [COLS];

  logic busy_int;
  logic sw_pend;
  logic w_rdy;
  logic load_en;

  assign w_rdy   = ~sw_pend;
  assign load_en = bus.w_valid & w_rdy & ~bus.sw_in;

  function automatic logic [ROW_W-1:0] clamp_rows(input logic [ROW_W-1:0] v);
    if (v == '0) return ROW_W'(1);
    if (v > ROW_W'(ROWS)) return ROW_W'(ROWS);
    return v;
  endfunction

  function automatic logic [COL_W-1:0] clamp_cols(input logic [COL_W-1:0] v);
    if (v == '0) return COL_W'(1);
    if (v > COL_W'(COLS)) return COL_W'(COLS);
    return v;
  endfunction

  // Shape only changes with the pipeline empty, so no vector ever sees a
  // mix of two configurations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_rows <= ROW_W'(ROWS);
      active_cols <= COL_W'(COLS);
    end else if (bus.cfg_valid && !busy_int && !bus.in_valid) begin
      active_rows <= clamp_rows(bus.cfg_rows);
      active_cols <= clamp_cols(bus.cfg_cols);
    end
  end

  // Input skew: row r waits r cycles before reaching PE(r,0).
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [DATA_W-1:0] x_masked;
    assign x_masked = (active_rows > ROW_W'(r)) ? bus.in_data[r*DATA_W +: DATA_W] : '0;

    if (r == 0) begin : g_direct
      assign act_in[0][0] = x_masked;
      assign v_in[0][0]   = bus.in_valid;
    end else begin : g_skew
      logic signed [DATA_W-1:0] sd [r];
      logic                     sv [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < r; k++) begin
            sd[k] <= '0;
            sv[k] <= 1'b0;
          end
        end else begin
          sd[0] <= x_masked;
          sv[0] <= bus.in_valid;
          for (int k = 1; k < r; k++) begin
            sd[k] <= sd[k-1];
            sv[k] <= sv[k-1];
          end
        end
      end
      assign act_in[r][0] = sd[r-1];
      assign v_in[r][0]   = sv[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pe_r
    for (genvar c = 0; c < COLS; c++) begin : g_pe_c
      logic signed [DATA_W-1:0]   shadow_q;
      logic signed [DATA_W-1:0]   active_q;
      logic signed [DATA_W-1:0]   shadow_in;
      logic signed [DATA_W-1:0]   w_use;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    psum_in;
      logic signed [ACC_W-1:0]    psum_q;
      logic                       v_q;
      logic                       keep;
      logic                       sw_sig;

      if (r == 0) begin : g_top
        assign psum_in   = '0;
        assign shadow_in = bus.w_data[c*DATA_W +: DATA_W];
      end else begin : g_inner
        assign psum_in   = psum[r-1][c];
        assign shadow_in = shadow[r-1][c];
      end

      // Swap wavefront: along row 0 first, then down each column, so
      // PE(r,c) switches exactly when a vector sampled with sw_in arrives.
      if (r == 0 && c == 0) begin : g_sw_src
        assign sw_sig = bus.sw_in;
      end else if (r == 0) begin : g_sw_row
        assign sw_sig = sw_bit[0][c-1];
      end else begin : g_sw_col
        assign sw_sig = sw_bit[r-1][c];
      end

      if ((r < ROWS - 1) || (r == 0 && c < COLS - 1)) begin : g_sw_reg
        logic sw_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sw_q <= 1'b0;
          else     sw_q <= sw_sig;
        end
        assign sw_bit[r][c] = sw_q;
      end else begin : g_sw_none
        assign sw_bit[r][c] = 1'b0;
      end

      // The switching PE already uses the new weight on the swap edge.
      assign w_use = sw_sig ? shadow_q : active_q;
      assign prod  = (2*DATA_W)'(act_in[r][c]) * (2*DATA_W)'(w_use);

      // Inactive columns are zeroed where the sum leaves the array.
      if (r == ROWS - 1) begin : g_bottom
        assign keep = v_in[r][c] && (active_cols > COL_W'(c));
      end else begin : g_mid
        assign keep = v_in[r][c];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_q <= '0;
          active_q <= '0;
          v_q      <= 1'b0;
          psum_q   <= '0;
        end else begin
          if (load_en) shadow_q <= shadow_in;
          if (sw_sig)  active_q <= shadow_q;
          v_q    <= v_in[r][c];
          psum_q <= keep ? (psum_in + ACC_W'(prod)) : '0;
        end
      end

      if (c < COLS - 1) begin : g_fwd
        logic signed [DATA_W-1:0] a_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) a_q <= '0;
          else     a_q <= act_in[r][c];
        end
        assign act_in[r][c+1] = a_q;
        assign v_in[r][c+1]   = v_q;
      end

      assign psum[r][c]   = psum_q;
      assign shadow[r][c] = shadow_q;
      assign v_bit[r][c]  = v_q;
    end
  end

  // Output deskew: column c trails the last column by COLS-1-c cycles.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_none
      assign col_res[c] = psum[ROWS-1][c];
    end else begin : g_dly
      logic signed [ACC_W-1:0] dq [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dq[k] <= '0;
        end else begin
          dq[0] <= psum[ROWS-1][c];
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign col_res[c] = dq[D-1];
    end
  end

  always_comb begin
    busy_int = 1'b0;
    sw_pend  = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        busy_int = busy_int | v_bit[r][c];
        sw_pend  = sw_pend | sw_bit[r][c];
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int c = 0; c < COLS; c++) bus.out_data[c*ACC_W +: ACC_W] = col_res[c];
  end

  assign bus.out_valid = v_bit[ROWS-1][COLS-1];
  assign bus.busy      = busy_int;
  assign bus.w_ready   = w_rdy;
endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;
  localparam int ROWS = 4, COLS = 4, DATA_W = 16, ACC_W = 32;
  localparam int LAT  = ROWS + COLS - 1;
  localparam int GUARD = ROWS + COLS - 2;

  typedef struct {
    logic [COLS*ACC_W-1:0] data;
    int                    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t exp_q[$];

  logic signed [DATA_W-1:0] m_act [ROWS][COLS];
  logic signed [DATA_W-1:0] m_sh  [ROWS][COLS];
  int m_rows, m_cols, last_in, sw_last;

  systolic_array_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  systolic_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic bit m_ready(input int e);
    return !(e >= sw_last + 1 && e <= sw_last + GUARD);
  endfunction

  function automatic bit m_busy(input int e);
    return last_in >= e - LAT;
  endfunction

  function automatic int clampv(input int v, input int mx);
    if (v == 0) return 1;
    if (v > mx) return mx;
    return v;
  endfunction

  // y[c] = sum over active rows of x[r]*W[r][c]; int arithmetic wraps mod 2^32.
  function automatic logic [COLS*ACC_W-1:0] expect_vec(input logic [63:0] x);
    logic [COLS*ACC_W-1:0] res;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      int s;
      s = 0;
      if (c < m_cols)
        for (int r = 0; r < m_rows; r++)
          s += int'($signed(x[r*DATA_W +: DATA_W])) * int'(m_act[r][c]);
      res[c*ACC_W +: ACC_W] = s;
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_act[r][c] = '0;
        m_sh[r][c]  = '0;
      end
    m_rows = ROWS; m_cols = COLS;
    last_in = -100; sw_last = -100;
  endtask

  // Called just after a falling edge; applies one cycle of stimulus and
  // predicts what the next rising edge does.
  task automatic drive(input bit iv, input logic [63:0] x, input bit sw, input bit wv,
                       input logic [63:0] wd, input bit cv, input int cr, input int cc);
    int   e;
    bit   rdy, bsy;
    exp_t item;
    e   = cyc + 1;
    rdy = m_ready(e);
    bsy = m_busy(e);
    bus.in_valid  = iv;
    bus.in_data   = x;
    bus.sw_in     = sw;
    bus.w_valid   = wv;
    bus.w_data    = wd;
    bus.cfg_valid = cv;
    bus.cfg_rows  = 3'(cr);
    bus.cfg_cols  = 3'(cc);
    check("w_ready", bus.w_ready, rdy);
    check("busy", bus.busy, bsy);
    if (wv && rdy && !sw) begin
      for (int r = ROWS - 1; r > 0; r--)
        for (int c = 0; c < COLS; c++) m_sh[r][c] = m_sh[r-1][c];
      for (int c = 0; c < COLS; c++) m_sh[0][c] = $signed(wd[c*DATA_W +: DATA_W]);
    end
    if (sw) begin
      m_act   = m_sh;
      sw_last = e;
    end
    if (cv && !bsy && !iv) begin
      m_rows = clampv(cr & 7, ROWS);
      m_cols = clampv(cc & 7, COLS);
    end
    if (iv) begin
      item.data = expect_vec(x);
      item.cyc  = e + LAT - 1;
      exp_q.push_back(item);
      last_in = e;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic vec(input logic [63:0] x);
    drive(1, x, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic swap();
    drive(0, '0, 1, 0, '0, 0, 0, 0);
  endtask

  task automatic cfg(input int cr, input int cc);
    drive(0, '0, 0, 0, '0, 1, cr, cc);
  endtask

  // Hold w_valid until the model says the row is taken.
  task automatic load_row(input logic [63:0] wd);
    bit done;
    done = 0;
    repeat (20) if (!done) begin
      done = m_ready(cyc + 1);
      drive(0, '0, 0, 1, wd, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.sw_in = 0; bus.w_valid = 0; bus.cfg_valid = 0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_w_ready", bus.w_ready, 1);
    check("rst_out_data", bus.out_data, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got %0h want no beat (cycle %0d)", bus.out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_cycle", cyc, e.cyc);
          check("out_data", bus.out_data, e.data);
        end
      end else begin
        check("idle_zero", bus.out_data, '0);
        if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
          e = exp_q.pop_front();
          total++; bad++;
          $display("FAIL missing_out: got no beat want %0h at cycle %0d", e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    int guard;
    bus.in_valid = 0; bus.in_data = '0; bus.sw_in = 0; bus.w_valid = 0; bus.w_data = '0;
    bus.cfg_valid = 0; bus.cfg_rows = '0; bus.cfg_cols = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Identity: rows loaded 3,2,1,0
    load_row(pack4(0, 0, 0, 1));
    load_row(pack4(0, 0, 1, 0));
    load_row(pack4(0, 1, 0, 0));
    load_row(pack4(1, 0, 0, 0));
    swap();
    vec(pack4(1, 2, 3, 4));
    idle(10);

    // Signed wrap, then swap coincident with a vector
    repeat (4) load_row(pack4(-32768, -32768, -32768, -32768));
    swap();
    vec(pack4(-32768, -32768, -32768, -32768));
    repeat (4) load_row(pack4(3, 3, 3, 3));
    drive(1, pack4(-1, -1, -1, -1), 1, 0, '0, 0, 0, 0);
    idle(10);

    // Streaming swap: A with old weights, B and C with new
    repeat (4) load_row({$urandom, $urandom});
    drive(1, {$urandom, $urandom}, 0, 0, '0, 0, 0, 0);
    drive(1, {$urandom, $urandom}, 1, 0, '0, 0, 0, 0);
    drive(1, {$urandom, $urandom}, 0, 0, '0, 0, 0, 0);
    idle(10);

    // Wavefront guard: w_valid held through the pending window
    drive(0, '0, 1, 1, pack4(9, 9, 9, 9), 0, 0, 0);
    for (int k = 1; k <= 8; k++) drive(0, '0, 0, 1, pack4(k, k + 1, k + 2, k + 3), 0, 0, 0);
    idle(8);
    drive(1, pack4(1, 2, 3, 4), 1, 0, '0, 0, 0, 0);
    idle(10);

    // Config
    cfg(3, 2);
    repeat (4) load_row(pack4(1, 1, 1, 1));
    swap();
    vec(pack4(1, 1, 1, 5));
    cfg(4, 4);
    vec(pack4(2, 1, 1, 5));
    idle(10);
    cfg(0, 7);
    vec(pack4(7, 1, 1, 5));
    drive(1, pack4(3, 1, 1, 5), 0, 0, '0, 1, 4, 4);
    idle(10);
    cfg(4, 4);

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      bit iv, sw, wv, cv;
      iv = ($urandom % 2) == 0;
      sw = ($urandom % 20) == 0;
      wv = ($urandom % 3) == 0;
      cv = ($urandom % 15) == 0;
      drive(iv, {$urandom, $urandom}, sw, wv, {$urandom, $urandom}, cv,
            $urandom_range(0, 7), $urandom_range(0, 7));
    end
    idle(10);

    // Reset mid-stream
    repeat (4) load_row({$urandom, $urandom});
    swap();
    vec({$urandom, $urandom});
    vec({$urandom, $urandom});
    vec({$urandom, $urandom});
    do_reset();
    idle(12);
    vec(pack4(5, 6, 7, 8));

    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      idle(1);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_array.md
# systolic_array

Parametrised ROWS×COLS weight-stationary systolic matrix-vector engine. It is the next generation of the fixed 2×2 array and feeds the unified-buffer read path.
- Activations are skewed internally.
- Weights are double-buffered per PE and swapped by a diagonal wavefront, so streaming never stalls.
- Column results are deskewed so each output vector appears on one aligned beat.
- Runtime row/column enables shrink the active matrix.

## Interface
Parameters:
- ROWS, 4: PE rows; inner (reduction) dimension.
- COLS, 4: PE columns; output vector length.
- DATA_W, 16: signed activation/weight width.
- ACC_W, 32: signed partial-sum/result width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  activation vector present.
- in_data  in  ROWS*DATA_W  element r at bits [r*DATA_W +: DATA_W].
- w_valid  in  1  weight row present.
- w_ready  out  1  weight load accepted this cycle.
- w_data  in  COLS*DATA_W  element c feeds the column c shadow chain.
- sw_in  in  1  one-cycle pulse; swap shadow→active weights.
- cfg_valid  in  1  apply cfg_rows/cfg_cols.
- cfg_rows  in  $clog2(ROWS+1)  active rows.
- cfg_cols  in  $clog2(COLS+1)  active columns.
- out_valid  out  1  result vector valid.
- out_data  out  COLS*ACC_W  element c at bits [c*ACC_W +: ACC_W].
- busy  out  1  any accepted vector not yet output.

## Operation
Skew and PE datapath:
- Row r of in_data is delayed by r registers before entering PE(r,0).
- Activation passes PE(r,c)→PE(r,c+1) with one register per hop, along with a valid bit.
- PE(r,c) on valid: psum_out ← psum_in + sext(act × W_use), modulo 2^ACC_W.
  - psum_in of row 0 is 0.
  - The product is full 2*DATA_W signed, sign-extended to ACC_W.
- PE(r,c) with no valid: psum_out ← 0.
- Rows r ≥ active_rows use act = 0.
- Columns c ≥ active_cols force out_data element c to 0.

Deskew:
- The bottom of column c is delayed a further COLS−1−c registers.
- All columns of one vector therefore land in the same output register.
- Result: out_data[c] = Σ_r x[r]·W[r][c].

Weights:
- Each PE holds a shadow and an active register.
- Accepted load (w_valid & w_ready & !sw_in):
  - shadow[0][c] ← w_data[c];
  - shadow[r][c] ← shadow[r−1][c].
- After ROWS loads, the first-loaded row sits in row ROWS−1.
- Switch wavefront: sw_in registers along row 0 (left to right), then down each column, one hop per cycle. PE(r,c) sees the switch at edge S+r+c, where S is the edge sampling sw_in.
- At that edge: active ← shadow, and W_use = shadow; otherwise W_use = active.
- Consequence: a vector sampled at edge S, or later, uses new weights in every PE; earlier vectors use old weights.
- w_ready = 0 while the wavefront is pending (edges S+1 … S+ROWS+COLS−2), i.e. w_ready is low for ROWS+COLS−2 cycles after the sw_in cycle; otherwise 1.
- w_valid with sw_in in the same cycle: the load is dropped, and the swap uses the old shadow.

Config:
- Accepted when cfg_valid & !busy & !in_valid; otherwise ignored.
- Values are clamped to [1,ROWS] / [1,COLS]; 0 becomes 1.

busy:
- OR of the in-flight valid pipeline.
- Goes high the cycle after in_valid is sampled.
- Goes low the cycle after the last out_valid.

## Timing
- Latency: in_valid sampled at edge E → out_valid = 1 during the cycle after edge E+ROWS+COLS−2, i.e. L = ROWS+COLS−1 edges.
- Throughput: one vector per cycle; back-to-back vectors produce back-to-back out_valid.
- out_valid and out_data are registered. out_data is 0 whenever out_valid is 0.
- Reset values:
  - out_valid = 0, out_data = 0, busy = 0, w_ready = 1.
  - All shadow/active weights = 0.
  - active_rows = ROWS, active_cols = COLS.
- Reset asserted mid-stream discards all in-flight vectors and any pending wavefront. There is no output until new input arrives.
- Simultaneous events:
  - in_valid + sw_in: that vector uses new weights.
  - cfg_valid + in_valid: cfg is ignored.

## Test plan
- **Identity.** ROWS=COLS=4; load W=I (4 loads, rows in order 3,2,1,0); sw_in; in [1,2,3,4] at edge E → out_valid exactly after edge E+6, out [1,2,3,4]; busy high 7 cycles.
- **Signed wrap.** DATA_W=16, ACC_W=32, ROWS=4; all W = −32768, x = −32768 → each product 2^30, sum wraps to 0. With x = −1 and W = 3 → −12 in each column.
- **Streaming swap.** Vectors A,B,C on consecutive cycles; new weights W2 shadowed; sw_in with B → A·W1, B·W2, C·W2 on three consecutive out_valid beats.
- **Wavefront guard.** ROWS=COLS=4; sw_in at S; w_valid held → w_ready low for 6 cycles after S and loads ignored; the first accepted load lands at edge S+7.
- **Config.** cfg_rows=3, cfg_cols=2 while idle; all-ones W, x = [1,1,1,5] → out [3,3,0,0]. cfg_valid while busy → ignored, previous config kept.
- **Reset mid-stream.** Three vectors in flight; rst pulse → out_valid/busy 0 immediately; no stale beats after release; weights read 0 (a subsequent vector gives all-zero output).
